logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//   Parametrised, pipelined bitwise logic unit: the WIDTH-bit, op-selectable successor to the
//   single-bit six-function gate block. Applies one of 8 bitwise ops to operands A and B.
//   Valid/ready handshake on both sides; accepts one op per clock.
//   An internal accumulator register can replace operand A for chained logic ops.
//   Sits between the switch/UART front end and the display/LED driver in the lab datapath.
// PARAMETERS
//   WIDTH      8   operand/result width in bits (legal 1..32)
//   ACC_INIT   0   accumulator value after reset (WIDTH bits)
// PORTS
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      synchronous reset, active low
//   in_valid   in   1      upstream presents a, b, op, acc_sel, acc_wr
//   in_ready   out  1      unit can accept an input this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   op         in   3      0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 PASS_A, 7 PASS_B
//   acc_sel    in   1      1: use accumulator instead of a as operand A
//   acc_wr     in   1      1: write result into accumulator when it enters stage 2
//   out_valid  out  1      z/zero/parity valid
//   out_ready  in   1      downstream accepts the result
//   z          out  WIDTH  result
//   zero       out  1      z == 0
//   parity     out  1      XOR-reduce of z
//   acc        out  WIDTH  current accumulator value, registered
// BEHAVIOUR
// - Reset (rst_n==0 at posedge): v1=v2=0, out_valid=0, z=0, zero=1, parity=0, acc=ACC_INIT.
//   in_ready=1 in the first cycle after reset. Reset mid-operation drops all in-flight ops silently.
// - Stage 1 (S1): registers a, b, op, acc_sel, acc_wr when in_valid && in_ready; sets v1.
// - Stage 2 (S2): computes result from S1 regs; registers z/zero/parity; sets v2 (=out_valid).
//   A-operand = acc_sel ? acc : a. All ops are bitwise over WIDTH; no carries; no width growth.
// - Advance rules:
//   adv2 = v1 && (!v2 || out_ready);
//   in_ready = !v1 || adv2 (combinational).
//   v1 clears when S1 moves to S2 with no new input. v2 clears on out_ready with no adv2.
// - Latency: 2 clocks from input acceptance to out_valid if no stall. Throughput: 1 op/clk.
// - Backpressure: while out_valid && !out_ready, z/zero/parity hold stable. S1 holds its contents.
//   in_ready drops once S1 is also full. No op is ever lost or duplicated.
// - Accumulator: on adv2 with S1.acc_wr=1, acc <= computed result at the same edge as z.
//   - Back-to-back acc_sel ops see the previous op's write (no hazard; S2 reads acc combinationally).
//   - acc is not written when acc_wr=0 or when S1 is empty/stalled.
//   - Loading acc: op=PASS_B, acc_wr=1. Clearing acc: PASS_B with b=0.
// - Simultaneous input accept and output accept in the same cycle: both happen; occupancy unchanged.
// - in_valid may drop without being accepted; no input stability requirement before acceptance.
// - out_valid does not depend combinationally on out_ready.
// TESTING (WIDTH=8 unless noted)
// 1. a=8'hF0, b=8'h3C, out_ready=1, op 0..7 back-to-back ->
//    z=30,CF,FC,03,CC,33,F0,3C on consecutive cycles starting 2 clks after first accept.
// 2. Accumulator chain: PASS_B b=8'hAA acc_wr=1; then XOR acc_sel=1 acc_wr=1 b=8'hFF; then AND acc_sel=1 b=8'h0F ->
//    z=AA, 55, 05; acc ends at 55 (last op has acc_wr=0).
// 3. Backpressure: out_ready=0 while in_valid=1 streams 3 ops ->
//    exactly 2 accepted, then in_ready=0 and z holds the first result.
//    Raise out_ready -> results appear in order, none lost or duplicated.
// 4. Flags: a=8'h0F, b=8'h0F, XOR -> z=00, zero=1, parity=0; OR with b=8'h01 -> z=0F, zero=0, parity=0.
//    a=8'h07, AND b=8'hFF -> parity=1.
// 5. Reset mid-stream: assert rst_n=0 for 1 clk with v1=v2=1 and acc=55 ->
//    out_valid=0, z=0, zero=1, acc=ACC_INIT, in_ready=1 next cycle.
// 6. WIDTH=1 and WIDTH=32 instances: random a/b/op with random out_ready ->
//    scoreboard matches bitwise model and in-order delivery.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready on both sides and an accumulator
// that can stand in for operand A so logic ops can be chained.
module logic_unit_pipe #(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_sel,
   input  logic             acc_wr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             zero,
   output logic             parity,
   output logic [WIDTH-1:0] acc
);

   typedef enum logic [2:0] {
      OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR, OP_PASS_A, OP_PASS_B
   } op_e;

   logic             v1_q, v2_q;
   logic [WIDTH-1:0] a_q, b_q;
   op_e              op_q;
   logic             sel_q, wr_q;
   logic [WIDTH-1:0] z_q, acc_q;
   logic             zero_q, par_q;

   logic             adv2, accept;
   logic [WIDTH-1:0] opa, res_d;

   assign adv2     = v1_q && (!v2_q || out_ready);
   assign in_ready = !v1_q || adv2;
   assign accept   = in_valid && in_ready;

   // acc_q already holds the previous op's write, so chained acc_sel ops need no bypass
   assign opa = sel_q ? acc_q : a_q;

   always_comb begin
      res_d = '0;
      case (op_q)
         OP_AND:    res_d = opa & b_q;
         OP_NAND:   res_d = ~(opa & b_q);
         OP_OR:     res_d = opa | b_q;
         OP_NOR:    res_d = ~(opa | b_q);
         OP_XOR:    res_d = opa ^ b_q;
         OP_XNOR:   res_d = ~(opa ^ b_q);
         OP_PASS_A: res_d = opa;
         OP_PASS_B: res_d = b_q;
         default:   res_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_AND;
         sel_q  <= 1'b0;
         wr_q   <= 1'b0;
         v2_q   <= 1'b0;
         z_q    <= '0;
         zero_q <= 1'b1;
         par_q  <= 1'b0;
         acc_q  <= ACC_INIT;
      end else begin
         if (accept) begin
            v1_q  <= 1'b1;
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_e'(op);
            sel_q <= acc_sel;
            wr_q  <= acc_wr;
         end else if (adv2) begin
            v1_q <= 1'b0;
         end

         if (adv2) begin
            v2_q   <= 1'b1;
            z_q    <= res_d;
            zero_q <= ~|res_d;
            par_q  <= ^res_d;
            if (wr_q) acc_q <= res_d;
         end else if (out_ready) begin
            v2_q <= 1'b0;
         end
      end
   end

   assign out_valid = v2_q;
   assign z         = z_q;
   assign zero      = zero_q;
   assign parity    = par_q;
   assign acc       = acc_q;

endmodule
